fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: PC register, PC+4 adder, word-addressed instruction memory loadable by the debug unit, and the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and the decode stage. It consumes the hazard unit's stall request, plus redirect requests from the branch/jump resolution logic. It also detects the HALT word so the debug unit can stop execution.

## Interface
Parameters:
- MEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two)
- ADDR_W, 8, word-address width, = log2(MEM_DEPTH)
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that halts fetch

Ports:
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance enable from debug unit (continuous/step mode)
- i_stall  in  1  1 = hold PC and IF/ID (load-use hazard)
- i_flush  in  1  1 = taken branch; redirect to i_branch_target, squash IF/ID
- i_branch_target  in  32  branch destination byte address
- i_jump  in  1  1 = jump; redirect to i_jump_target, squash IF/ID
- i_jump_target  in  32  jump destination byte address
- i_inst_we  in  1  instruction memory write enable (debug loader)
- i_inst_addr  in  ADDR_W  word address for loader write
- i_inst_data  in  32  loader write data
- o_pc  out  32  current PC
- o_instruction  out  32  IF/ID instruction
- o_pc_plus4  out  32  IF/ID PC+4
- o_valid  out  1  IF/ID holds a real (non-squashed) instruction
- o_halted  out  1  HALT_WORD has been latched into IF/ID; fetch frozen

## Operation
- Fetch word = mem[o_pc[ADDR_W+1:2]], combinational read. Upper PC bits and PC[1:0] are ignored, so addresses wrap modulo MEM_DEPTH words.
- Loader write: on an edge with i_inst_we=1, mem[i_inst_addr] <= i_inst_data. This works regardless of i_enable, stall or halt. Memory is not cleared by reset.
- Read-during-write to the same address returns the old word in that cycle.
- Per-edge priority, highest first:
  1. i_reset=0: PC=0, o_instruction=0, o_pc_plus4=0, o_valid=0, o_halted=0.
  2. i_enable=0: all registers hold. Flush, jump and stall are ignored.
  3. i_flush=1: PC <= i_branch_target; IF/ID <= {instr 0 (NOP), pc_plus4 0, valid 0}; o_halted <= 0.
  4. i_jump=1: same as flush, but PC <= i_jump_target.
  5. o_halted=1: PC and IF/ID hold.
  6. i_stall=1: PC and IF/ID hold.
  7. Normal: PC <= PC+4 (mod 2^32); o_instruction <= fetch word; o_pc_plus4 <= PC+4; o_valid <= 1. If the fetch word == HALT_WORD, o_halted <= 1 on the same edge.
- Flush and jump asserted together: flush wins, because the branch is the older instruction.
- Redirect versus stall: a redirect wins, and the stalled fetch is squashed.
- A flush or jump while halted clears o_halted. The HALT was on a wrong path.
- A flush or jump on the edge where HALT is fetched: the HALT is squashed and o_halted stays 0.
- Once halted, only reset or a redirect resumes fetch.

## Timing
- All outputs are registered. Reset values: o_pc=0, o_instruction=0, o_pc_plus4=0, o_valid=0, o_halted=0.
- Reset is asynchronous on assertion. After release, the first edge with i_enable=1 fetches address 0, and o_valid=1 after that edge.
- Fetch latency: 1 cycle, from PC value to IF/ID.
- Redirect: target appears on o_pc one edge after i_flush/i_jump. The target instruction is in IF/ID one edge later, giving 1 bubble.
- Stall: each stalled edge repeats the same IF/ID contents. No instruction is lost or duplicated after the stall releases.
- Step mode: a one-cycle i_enable pulse advances exactly one edge.
- Reset mid-operation: outputs clear immediately. Memory contents are retained.

## Test plan
- Load mem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF; release reset; i_enable=1.
  - IF/ID sequence: 0x20010005/pc4=4, 0x20020007/8, 0x00221820/12, 0xFFFFFFFF/16.
  - o_halted=1 on that last edge; o_pc stays 16 thereafter.
- Assert i_stall for 2 cycles while IF/ID holds 0x20020007 (o_pc=8).
  - Outputs hold 2 edges; next edge yields 0x00221820, pc4=12.
- i_flush=1 with i_branch_target=0x40, i_stall=1 and i_jump=1 (i_jump_target=0x80), all in the same cycle.
  - Next edge: o_pc=0x40, o_instruction=0, o_valid=0.
  - Following edge: o_instruction=mem[16], o_pc_plus4=0x44.
- Halted at o_pc=16, then i_jump=1 with target 0.
  - o_halted=0, o_pc=0; fetch resumes with 0x20010005.
- i_enable=0 with a flush pending plus a loader write of mem[5]=0x12345678.
  - PC and IF/ID unchanged; the write lands; a later fetch at 0x14 returns 0x12345678.
- Drive PC to 0x400 via a jump with MEM_DEPTH=256; fetch returns mem[0], confirming wrap. Then assert reset mid-run: all outputs are 0 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, loadable instruction memory, IF/ID register
module fetch_stage #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [31:0]       i_branch_target,
    input  logic              i_jump,
    input  logic [31:0]       i_jump_target,
    input  logic              i_inst_we,
    input  logic [ADDR_W-1:0] i_inst_addr,
    input  logic [31:0]       i_inst_data,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc_plus4,
    output logic              o_valid,
    output logic              o_halted
);

    logic [31:0] r_mem [MEM_DEPTH];
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic        r_halted;

    logic [31:0] w_fetch_word;
    logic [31:0] w_pc_next_seq;
    logic        w_redirect;
    logic [31:0] w_redirect_target;

    // Word-indexed read; upper PC bits drop out so fetch wraps around the memory.
    assign w_fetch_word      = r_mem[r_pc[ADDR_W+1:2]];
    assign w_pc_next_seq     = r_pc + 32'd4;
    assign w_redirect        = i_flush | i_jump;
    assign w_redirect_target = i_flush ? i_branch_target : i_jump_target;

    // Loader port is independent of reset, enable, stall and halt.
    always_ff @(posedge i_clk) begin
        if (i_inst_we) begin
            r_mem[i_inst_addr] <= i_inst_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc          <= 32'd0;
            r_instruction <= 32'd0;
            r_pc_plus4    <= 32'd0;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
        end else if (i_enable) begin
            if (w_redirect) begin
                r_pc          <= w_redirect_target;
                r_instruction <= 32'd0;
                r_pc_plus4    <= 32'd0;
                r_valid       <= 1'b0;
                r_halted      <= 1'b0;
            end else if (!r_halted && !i_stall) begin
                r_pc          <= w_pc_next_seq;
                r_instruction <= w_fetch_word;
                r_pc_plus4    <= w_pc_next_seq;
                r_valid       <= 1'b1;
                r_halted      <= (w_fetch_word == HALT_WORD);
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a behavioural reference model
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_inst_we;
    logic [7:0]  i_inst_addr;
    logic [31:0] i_inst_data;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halted;

    fetch_stage #(.MEM_DEPTH(256), .ADDR_W(8), .HALT_WORD(HALT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
        .i_flush(i_flush), .i_branch_target(i_branch_target), .i_jump(i_jump),
        .i_jump_target(i_jump_target), .i_inst_we(i_inst_we), .i_inst_addr(i_inst_addr),
        .i_inst_data(i_inst_data), .o_pc(o_pc), .o_instruction(o_instruction),
        .o_pc_plus4(o_pc_plus4), .o_valid(o_valid), .o_halted(o_halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;

    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cycle, got, exp);
        end
    endtask

    // Monitor: every negedge compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_pc",     o_pc,                 e.pc);
                chk("sb_instr",  o_instruction,        e.instr);
                chk("sb_pc4",    o_pc_plus4,           e.pc4);
                chk("sb_valid",  {31'd0, o_valid},     {31'd0, e.valid});
                chk("sb_halted", {31'd0, o_halted},    {31'd0, e.halted});
            end
        end
    end

    function automatic void model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    endfunction

    // Drive one clock edge worth of inputs, advance the reference model, queue its result.
    task automatic step(input bit rst, input bit en, input bit stall, input bit flush,
                        input logic [31:0] bt, input bit jump, input logic [31:0] jt,
                        input bit we, input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] fw;
        exp_t e;
        @(negedge i_clk);
        #1;
        i_reset = rst; i_enable = en; i_stall = stall; i_flush = flush;
        i_branch_target = bt; i_jump = jump; i_jump_target = jt;
        i_inst_we = we; i_inst_addr = wa; i_inst_data = wd;
        fw = m_mem[m_pc[9:2]];
        if (!rst) begin
            model_reset();
        end else if (en) begin
            if (flush || jump) begin
                m_pc = flush ? bt : jt;
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
            end else if (!m_halted && !stall) begin
                m_instr  = fw;
                m_pc4    = m_pc + 4;
                m_valid  = 1;
                m_halted = (fw == HALT);
                m_pc     = m_pc + 4;
            end
        end
        if (we) m_mem[wa] = wd;
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.halted = m_halted;
        q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_out(input string name, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pc4, input bit v, input bit h);
        chk({name, "_pc"},     o_pc,          pc);
        chk({name, "_instr"},  o_instruction, ins);
        chk({name, "_pc4"},    o_pc_plus4,    pc4);
        chk({name, "_valid"},  {31'd0, o_valid},  {31'd0, v});
        chk({name, "_halted"}, {31'd0, o_halted}, {31'd0, h});
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] mem16;
        i_reset = 0; i_enable = 0; i_stall = 0; i_flush = 0; i_branch_target = 0;
        i_jump = 0; i_jump_target = 0; i_inst_we = 0; i_inst_addr = 0; i_inst_data = 0;
        model_reset();
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);

        // Preload memory under reset; sprinkle HALT words beyond the program.
        for (int a = 0; a < 256; a++) begin
            case (a)
                0: w = 32'h2001_0005;
                1: w = 32'h2002_0007;
                2: w = 32'h0022_1820;
                3: w = HALT;
                default: w = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            endcase
            step(0, 1, 0, 0, 0, 0, 0, 1, a[7:0], w);
        end
        mem16 = m_mem[16];

        run(2);
        chk_out("seq2", 8, 32'h2002_0007, 8, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_out("stall1", 8, 32'h2002_0007, 8, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_out("stall2", 8, 32'h2002_0007, 8, 1, 0);
        run(1);
        chk_out("seq3", 12, 32'h0022_1820, 12, 1, 0);
        run(1);
        chk_out("halt", 16, HALT, 16, 1, 1);
        run(3);
        chk_out("halt_hold", 16, HALT, 16, 1, 1);

        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_out("jump_unhalt", 0, 0, 0, 0, 0);
        run(1);
        chk_out("resume", 4, 32'h2001_0005, 4, 1, 0);

        step(1, 1, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0);
        chk_out("flush_prio", 32'h40, 0, 0, 0, 0);
        run(1);
        chk("flush_tgt_instr", o_instruction, mem16);
        chk("flush_tgt_pc4", o_pc_plus4, 32'h44);

        w = o_instruction;
        step(1, 0, 0, 1, 32'h100, 0, 0, 1, 8'd5, 32'h1234_5678);
        chk("disabled_pc", o_pc, 32'h44);
        chk("disabled_instr", o_instruction, w);
        step(1, 1, 0, 0, 0, 1, 32'h14, 0, 0, 0);
        run(1);
        chk("loaded_word", o_instruction, 32'h1234_5678);

        step(1, 1, 0, 0, 0, 1, 32'h400, 0, 0, 0);
        run(1);
        chk("wrap_instr", o_instruction, 32'h2001_0005);
        chk("wrap_pc4", o_pc_plus4, 32'h404);

        // Asynchronous reset between edges: outputs clear before any clock.
        @(negedge i_clk);
        #2;
        i_reset = 0;
        #1;
        chk_out("async_reset", 0, 0, 0, 0, 0);
        model_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run(2);
        chk("post_reset_instr", o_instruction, 32'h2002_0007);

        for (int k = 0; k < 3000; k++) begin
            bit rst, en, st, fl, jp, we;
            logic [31:0] bt, jt, wd;
            rst = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            jp  = ($urandom_range(0, 15) == 0);
            we  = ($urandom_range(0, 9) == 0);
            bt  = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, $urandom_range(0, 255), 2'b00};
            jt  = {22'd0, $urandom_range(0, 255), 2'b00};
            wd  = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
            step(rst, en, st, fl, bt, jp, jt, we, 8'($urandom_range(0, 255)), wd);
        end

        @(negedge i_clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
